// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-request bus master sequencing direct/indirect accesses into a synchronous word RAM
module mem_master #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDRESS_SIZE = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  input  logic [WORD_SIZE-1:0]    req_data,
  output logic                    resp_valid,
  output logic [WORD_SIZE-1:0]    resp_data,
  output logic [ADDRESS_SIZE-1:0] resp_address,
  output logic                    ram_read,
  output logic                    ram_write,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [WORD_SIZE-1:0]    ram_in_data,
  input  logic [WORD_SIZE-1:0]    ram_out_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PTR_RD   = 3'd1;
  localparam logic [2:0] S_PTR_CAP  = 3'd2;
  localparam logic [2:0] S_DATA_RD  = 3'd3;
  localparam logic [2:0] S_DATA_CAP = 3'd4;
  localparam logic [2:0] S_DATA_WR  = 3'd5;

  localparam logic [1:0] OP_READ      = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_WRITE_IND = 2'b11;

  logic [2:0]              state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0]    resp_data_q, resp_data_d;
  logic [ADDRESS_SIZE-1:0] resp_address_q, resp_address_d;
  logic                    ram_read_q, ram_read_d;
  logic                    ram_write_q, ram_write_d;
  logic [ADDRESS_SIZE-1:0] ram_address_q, ram_address_d;
  logic [WORD_SIZE-1:0]    ram_in_data_q, ram_in_data_d;

  // Every output is registered, so the next-state logic computes the value each
  // output takes in the state being entered (strobes are pulses of that state).
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wdata_d        = wdata_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_address_d = resp_address_q;
    ram_read_d     = 1'b0;
    ram_write_d    = 1'b0;
    ram_address_d  = ram_address_q;
    ram_in_data_d  = ram_in_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d          = req_op;
          wdata_d       = req_data;
          ram_address_d = req_address;
          if (req_op == OP_READ) begin
            state_d    = S_DATA_RD;
            ram_read_d = 1'b1;
          end else if (req_op == OP_WRITE) begin
            state_d       = S_DATA_WR;
            ram_write_d   = 1'b1;
            ram_in_data_d = req_data;
          end else begin
            state_d    = S_PTR_RD;
            ram_read_d = 1'b1;
          end
        end
      end
      S_PTR_RD: state_d = S_PTR_CAP;
      S_PTR_CAP: begin
        // The fetched pointer becomes the effective address; upper bits dropped.
        ram_address_d = ram_out_data[ADDRESS_SIZE-1:0];
        if (op_q == OP_WRITE_IND) begin
          state_d       = S_DATA_WR;
          ram_write_d   = 1'b1;
          ram_in_data_d = wdata_q;
        end else begin
          state_d    = S_DATA_RD;
          ram_read_d = 1'b1;
        end
      end
      S_DATA_RD: state_d = S_DATA_CAP;
      S_DATA_CAP: begin
        state_d        = S_IDLE;
        resp_valid_d   = 1'b1;
        resp_data_d    = ram_out_data;
        resp_address_d = ram_address_q;
      end
      S_DATA_WR: begin
        state_d        = S_IDLE;
        resp_valid_d   = 1'b1;
        resp_data_d    = wdata_q;
        resp_address_d = ram_address_q;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      op_q           <= 2'b00;
      wdata_q        <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_address_q <= '0;
      ram_read_q     <= 1'b0;
      ram_write_q    <= 1'b0;
      ram_address_q  <= '0;
      ram_in_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      wdata_q        <= wdata_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_address_q <= resp_address_d;
      ram_read_q     <= ram_read_d;
      ram_write_q    <= ram_write_d;
      ram_address_q  <= ram_address_d;
      ram_in_data_q  <= ram_in_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_address = resp_address_q;
  assign ram_read     = ram_read_q;
  assign ram_write    = ram_write_q;
  assign ram_address  = ram_address_q;
  assign ram_in_data  = ram_in_data_q;

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - scoreboard bench for mem_master against a behavioural synchronous RAM
module tb_mem_master;

  localparam int P = 10;
  localparam logic [1:0] OP_READ      = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_READ_IND  = 2'b10;
  localparam logic [1:0] OP_WRITE_IND = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_address;
  logic [15:0] req_data;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [15:0] resp_address;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] ram_address;
  logic [15:0] ram_in_data;
  logic [15:0] ram_out_data;

  always #(P/2) clock = ~clock;

  mem_master #(.WORD_SIZE(16), .ADDRESS_SIZE(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_address  (req_address),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_address (resp_address),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_address  (ram_address),
    .ram_in_data  (ram_in_data),
    .ram_out_data (ram_out_data)
  );

  // Synchronous single-port RAM: write and registered read on the rising edge.
  logic [15:0] mem  [0:255];
  logic [15:0] snap [0:255];
  always @(posedge clock) begin
    if (ram_write) mem[ram_address[7:0]] <= ram_in_data;
    if (ram_read)  ram_out_data <= mem[ram_address[7:0]];
  end

  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    int          lat;
    time         t;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop the oldest expectation whenever a response appears.
  always @(negedge clock) begin
    if (ram_read && ram_write) overlap++;
    if (resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 addr %h expected no response", resp_address);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", {16'h0, resp_data}, {16'h0, e.d});
        chk("resp_address", {16'h0, resp_address}, {16'h0, e.a});
        chk("latency", int'(($time - e.t - P/2) / P), e.lat);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                       input bit expect_resp, input logic [15:0] ed, input logic [15:0] ea,
                       input int lat, output time tacc);
    req_op      = op;
    req_address = a;
    req_data    = d;
    req_valid   = 1'b1;
    tacc        = 0;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clock);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 for addr %h", a);
      return;
    end
    @(posedge clock);
    tacc = $time;
    if (expect_resp) q.push_back('{ed, ea, lat, $time});
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_read"},     {31'h0, ram_read},   32'h0);
    chk({tag, "_ram_write"},    {31'h0, ram_write},  32'h0);
    chk({tag, "_req_ready"},    {31'h0, req_ready},  32'h1);
    chk({tag, "_resp_valid"},   {31'h0, resp_valid}, 32'h0);
    chk({tag, "_ram_address"},  {16'h0, ram_address},  32'h0);
    chk({tag, "_resp_address"}, {16'h0, resp_address}, 32'h0);
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < 256; i++) snap[i] = mem[i];
  endtask

  function automatic int count_diffs(input int skip);
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (i != skip && mem[i] !== snap[i]) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    time t0, t1, t2, trel;
    reset_n     = 1'b0;
    req_valid   = 1'b1;
    req_op      = OP_READ;
    req_address = 16'h0000;
    req_data    = 16'h0000;

    // Reset held with a pending request: nothing may reach the RAM.
    repeat (3) begin
      @(negedge clock);
      check_reset_outputs("reset_hold");
    end
    reset_n = 1'b1;
    trel    = $time;
    issue(OP_WRITE, 16'h0000, 16'h2603, 1, 16'h2603, 16'h0000, 1, t0);
    chk("accept_after_release", int'(t0 - trel), P/2);

    // Direct read/write.
    issue(OP_READ,  16'h0000, 16'h0000, 1, 16'h2603, 16'h0000, 2, t0);
    issue(OP_WRITE, 16'h0003, 16'hBEEF, 1, 16'hBEEF, 16'h0003, 1, t0);
    issue(OP_READ,  16'h0003, 16'h0000, 1, 16'hBEEF, 16'h0003, 2, t0);

    // Indirect: pointers at 5 and 6.
    issue(OP_WRITE, 16'h0005, 16'h0000, 1, 16'h0000, 16'h0005, 1, t0);
    issue(OP_WRITE, 16'h0006, 16'h0003, 1, 16'h0003, 16'h0006, 1, t0);
    issue(OP_WRITE, 16'h0000, 16'h1234, 1, 16'h1234, 16'h0000, 1, t0);
    issue(OP_READ_IND,  16'h0005, 16'h0000, 1, 16'h1234, 16'h0000, 4, t0);
    issue(OP_WRITE_IND, 16'h0006, 16'h5A5A, 1, 16'h5A5A, 16'h0003, 3, t0);
    drain();
    chk("mem3_after_sti", {16'h0, mem[3]}, 32'h5A5A);
    chk("mem6_pointer", {16'h0, mem[6]}, 32'h0003);

    // Back-to-back with req_valid held high.
    issue(OP_WRITE, 16'h0010, 16'h0001, 1, 16'h0001, 16'h0010, 1, t1);
    issue(OP_READ,  16'h0010, 16'h0000, 1, 16'h0001, 16'h0010, 2, t2);
    chk("b2b_accept_spacing", int'(t2 - t1), 2 * P);
    drain();

    // Request inputs wander after accept; only the captured write may land.
    take_snapshot();
    issue(OP_WRITE, 16'h0020, 16'h00AA, 1, 16'h00AA, 16'h0020, 1, t0);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_address = 16'h0040 + 16'(i);
      req_data    = 16'hC000 + 16'(i);
      req_op      = 2'(i);
      @(negedge clock);
    end
    drain();
    chk("mem20_written", {16'h0, mem[8'h20]}, 32'h00AA);
    chk("stability_other_locations", count_diffs(32), 0);

    // Reset during PTR_CAP of a WRITE_IND.
    take_snapshot();
    issue(OP_WRITE_IND, 16'h0006, 16'h7777, 0, 16'h0000, 16'h0000, 0, t0);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_now");
    @(negedge clock);
    check_reset_outputs("reset_mid_held");
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_mid_mem_unchanged", count_diffs(-1), 0);
    chk("reset_mid_mem3", {16'h0, mem[3]}, 32'h5A5A);
    issue(OP_READ, 16'h0003, 16'h0000, 1, 16'h5A5A, 16'h0003, 2, t0);
    drain();

    chk("read_write_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
